rgbw_fade_engine: RTL and testbench

- Parametrised next-generation lamp core: N PWM channels with configurable resolution, linear fade toward per-channel targets, and global intensity scaling.
- Sits between the SPI byte receiver (byte + ready strobe) and the LED pins.
- Time-shares one sequential 8x8 multiplier across all channels.

---
 rtl/lamp_pkg.sv | 28 ++
 rtl/seq_mult8x8.sv | 78 +++++++
 rtl/rgbw_fade_engine.sv | 278 +++++++++++++++++++++++++++
 tb/tb_rgbw_fade_engine.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lamp_pkg.sv
// -----------------------------------------------------------------------------
// lamp_pkg
// Shared definitions for the RGBW fade engine:
//   - command bytes that open a frame on the SPI byte stream
//   - parser state encoding
//   - full-scale duty helper (2^dw - 1, for dw up to 16)
// -----------------------------------------------------------------------------
package lamp_pkg;

    // First byte of a frame selects what follows.
    localparam logic [7:0] CMD_TGT = 8'hA5;   // CH target bytes, then a rate byte
    localparam logic [7:0] CMD_INT = 8'h5A;   // one intensity byte

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TGT  = 2'd1,
        RATE = 2'd2,
        INT  = 2'd3
    } parse_state_t;

    // All-ones duty value for a counter of dw bits, returned in 16 bits.
    function automatic logic [15:0] full_scale_duty(input int unsigned dw);
        logic [16:0] one_hot;
        one_hot = 17'd1 << dw;
        return 16'(one_hot - 17'd1);
    endfunction

endpackage

// File: rtl/seq_mult8x8.sv
// -----------------------------------------------------------------------------
// seq_mult8x8
// Iterative shift-add 8x8 unsigned multiplier, one partial product per cycle.
// Ports:
//   clk12   in   system clock
//   reset   in   synchronous active-low reset
//   ld      in   capture a/b and start; a new ld abandons any multiply in flight
//   a, b    in   8-bit operands
//   rdy     out  one-cycle pulse 8 cycles after ld; result valid while high
//   result  out  16-bit product a*b (held until the next ld)
// -----------------------------------------------------------------------------
module seq_mult8x8 (
    input  logic        clk12,
    input  logic        reset,
    input  logic        ld,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        rdy,
    output logic [15:0] result
);

    logic [15:0] mcand_q, mcand_d;   // multiplicand, shifted left each step
    logic [7:0]  mplier_q, mplier_d; // multiplier, shifted right each step
    logic [15:0] acc_q, acc_d;
    logic [2:0]  step_q, step_d;
    logic        run_q, run_d;
    logic        rdy_q, rdy_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        step_d   = step_q;
        run_d    = run_q;
        rdy_d    = 1'b0;
        if (ld) begin
            mcand_d  = {8'h00, a};
            mplier_d = b;
            acc_d    = 16'h0000;
            step_d   = 3'd0;
            run_d    = 1'b1;
        end else if (run_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            step_d   = step_q + 3'd1;
            // Eighth partial product lands this edge; flag it next cycle.
            if (step_q == 3'd7) begin
                run_d = 1'b0;
                rdy_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk12) begin
        if (!reset) begin
            mcand_q  <= 16'h0000;
            mplier_q <= 8'h00;
            acc_q    <= 16'h0000;
            step_q   <= 3'd0;
            run_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            step_q   <= step_d;
            run_q    <= run_d;
            rdy_q    <= rdy_d;
        end
    end

    assign rdy    = rdy_q;
    assign result = acc_q;

endmodule

// File: rtl/rgbw_fade_engine.sv
// -----------------------------------------------------------------------------
// rgbw_fade_engine
// N-channel PWM lamp core. Parses command frames from an SPI byte receiver,
// fades each channel level linearly toward its target, scales levels by a
// global intensity with one time-shared sequential multiplier, and drives
// glitch-free PWM outputs.
// Parameters:
//   CH     number of PWM channels (1..8)
//   DW     PWM resolution in bits (8..16)
//   PRESC  clk12 cycles per PWM counter increment (>=1)
// Ports:
//   clk12        in   system clock
//   reset        in   synchronous active-low reset
//   rx_data      in   received byte
//   rx_rdy       in   one-cycle strobe, rx_data valid
//   frame_abort  in   chip-select released; parser returns to IDLE
//   pwm_out      out  PWM outputs, bit k = channel k
//   busy         out  high while any level differs from its target
//   frame_err    out  one-cycle pulse on an unknown command byte
// -----------------------------------------------------------------------------
module rgbw_fade_engine
    import lamp_pkg::*;
#(
    parameter int CH    = 4,
    parameter int DW    = 8,
    parameter int PRESC = 4
) (
    input  logic          clk12,
    input  logic          reset,
    input  logic [7:0]    rx_data,
    input  logic          rx_rdy,
    input  logic          frame_abort,
    output logic [CH-1:0] pwm_out,
    output logic          busy,
    output logic          frame_err
);

    localparam int              IDXW      = (CH > 1) ? $clog2(CH) : 1;
    localparam int              PW        = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [15:0]     FULL16    = full_scale_duty(DW);
    localparam logic [DW-1:0]   DUTY_FULL = FULL16[DW-1:0];

    // ------------------------------------------------------------------
    // Frame parser
    // ------------------------------------------------------------------
    parse_state_t    state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [7:0]      shadow_q [CH];
    logic [7:0]      shadow_d [CH];
    logic [7:0]      target_q [CH];
    logic [7:0]      target_d [CH];
    logic [7:0]      rate_q, rate_d;
    logic [7:0]      intensity_q, intensity_d;
    logic            frame_err_q, frame_err_d;
    logic            commit;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        target_d    = target_q;
        rate_d      = rate_q;
        intensity_d = intensity_q;
        frame_err_d = 1'b0;
        commit      = 1'b0;
        // Abort wins over a byte arriving in the same cycle.
        if (frame_abort) begin
            state_d = IDLE;
            idx_d   = '0;
            for (int k = 0; k < CH; k++) begin
                shadow_d[k] = 8'h00;
            end
        end else if (rx_rdy) begin
            case (state_q)
                IDLE: begin
                    if (rx_data == CMD_TGT) begin
                        state_d = TGT;
                        idx_d   = '0;
                    end else if (rx_data == CMD_INT) begin
                        state_d = INT;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                TGT: begin
                    shadow_d[idx_q] = rx_data;
                    if (idx_q == IDXW'(CH - 1)) begin
                        state_d = RATE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                RATE: begin
                    // Targets only change as a complete set.
                    target_d = shadow_q;
                    rate_d   = rx_data;
                    commit   = 1'b1;
                    state_d  = IDLE;
                    idx_d    = '0;
                end
                INT: begin
                    intensity_d = rx_data;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk12) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            for (int k = 0; k < CH; k++) begin
                shadow_q[k] <= 8'h00;
                target_q[k] <= 8'h00;
            end
            rate_q      <= 8'h00;
            intensity_q <= 8'hFF;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            target_q    <= target_d;
            rate_q      <= rate_d;
            intensity_q <= intensity_d;
            frame_err_q <= frame_err_d;
        end
    end

    // ------------------------------------------------------------------
    // PWM timebase and fade-tick divider
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_q;
    logic [DW-1:0] cnt_q;
    logic [7:0]    fade_cnt_q;
    logic          busy_q;
    logic          presc_tick;
    logic          period_end;
    logic          fade_tick;
    logic [CH-1:0] diff;

    assign presc_tick = (presc_q == PW'(PRESC - 1));
    // Counter is about to wrap to 0: end of a PWM period.
    assign period_end = presc_tick && (cnt_q == {DW{1'b1}});
    assign fade_tick  = period_end && (fade_cnt_q == rate_q);

    always_ff @(posedge clk12) begin
        if (!reset) begin
            presc_q    <= '0;
            cnt_q      <= '0;
            fade_cnt_q <= 8'h00;
            busy_q     <= 1'b0;
        end else begin
            presc_q <= presc_tick ? '0 : presc_q + 1'b1;
            if (presc_tick) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (commit) begin
                fade_cnt_q <= 8'h00;
            end else if (period_end) begin
                fade_cnt_q <= fade_tick ? 8'h00 : fade_cnt_q + 8'd1;
            end
            busy_q <= |diff;
        end
    end

    // ------------------------------------------------------------------
    // Intensity scaling: one multiplier visits channels round-robin.
    // ------------------------------------------------------------------
    logic [CH*8-1:0] level_flat;
    logic [7:0]      level_arr [CH];
    logic [DW-1:0]   duty_q [CH];
    logic [IDXW-1:0] sch_q;          // channel whose product is in flight
    logic [IDXW-1:0] next_ch;
    logic [IDXW-1:0] ld_ch;
    logic            kick_q;         // starts the very first multiply after reset
    logic            sat_q;          // in-flight operands were both 0xFF
    logic            mult_ld;
    logic            mult_rdy;
    logic [7:0]      mult_a;
    logic [15:0]     mult_result;

    always_comb begin
        for (int k = 0; k < CH; k++) begin
            level_arr[k] = level_flat[k*8 +: 8];
        end
        next_ch = (sch_q == IDXW'(CH - 1)) ? '0 : sch_q + 1'b1;
        // The next load is issued in the same cycle the previous result
        // arrives, so each channel costs exactly 9 cycles.
        ld_ch   = kick_q ? sch_q : next_ch;
        mult_a  = level_arr[ld_ch];
    end

    assign mult_ld = kick_q | mult_rdy;

    seq_mult8x8 u_mult (
        .clk12  (clk12),
        .reset  (reset),
        .ld     (mult_ld),
        .a      (mult_a),
        .b      (intensity_q),
        .rdy    (mult_rdy),
        .result (mult_result)
    );

    always_ff @(posedge clk12) begin
        if (!reset) begin
            kick_q <= 1'b1;
            sch_q  <= '0;
            sat_q  <= 1'b0;
            for (int k = 0; k < CH; k++) begin
                duty_q[k] <= '0;
            end
        end else begin
            kick_q <= 1'b0;
            if (mult_rdy) begin
                // 0xFF*0xFF would otherwise top out one LSB short of full on.
                duty_q[sch_q] <= sat_q ? DUTY_FULL : mult_result[15 -: DW];
            end
            if (mult_ld) begin
                sch_q <= ld_ch;
                sat_q <= (mult_a == 8'hFF) && (intensity_q == 8'hFF);
            end
        end
    end

    // Low product bits fall below the PWM resolution when DW < 16.
    logic unused_prod;
    assign unused_prod = &{1'b0, mult_result};

    // ------------------------------------------------------------------
    // Per-channel fade and PWM output
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            logic [7:0]    level_q, level_d;
            logic [DW-1:0] duty_lat_q;
            logic          pwm_q;

            always_comb begin
                level_d = level_q;
                if (fade_tick) begin
                    if (level_q < target_q[gi]) begin
                        level_d = level_q + 8'd1;
                    end else if (level_q > target_q[gi]) begin
                        level_d = level_q - 8'd1;
                    end
                end
            end

            always_ff @(posedge clk12) begin
                if (!reset) begin
                    level_q    <= 8'h00;
                    duty_lat_q <= '0;
                    pwm_q      <= 1'b0;
                end else begin
                    level_q <= level_d;
                    // Duty only changes at the wrap so no period is cut short.
                    if (period_end) begin
                        duty_lat_q <= duty_q[gi];
                    end
                    pwm_q <= (cnt_q < duty_lat_q);
                end
            end

            assign level_flat[gi*8 +: 8] = level_q;
            assign diff[gi]              = (level_q != target_q[gi]);
            assign pwm_out[gi]           = pwm_q;
        end
    endgenerate

    assign busy      = busy_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_rgbw_fade_engine.sv
// -----------------------------------------------------------------------------
// tb_rgbw_fade_engine
// Directed frames drive the byte interface; expected PWM high counts (per
// 256-cycle period) and busy levels are queued by the stimulus and checked by
// a window monitor. Expected frame_err pulses go into a second queue checked
// by a pulse monitor.
// -----------------------------------------------------------------------------
module tb_rgbw_fade_engine;

    localparam int CH    = 4;
    localparam int DW    = 8;
    localparam int PRESC = 1;
    localparam int W     = (1 << DW) * PRESC;   // clk12 cycles per PWM period

    logic          clk12 = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_rdy = 1'b0;
    logic          frame_abort = 1'b0;
    logic [CH-1:0] pwm_out;
    logic          busy;
    logic          frame_err;

    rgbw_fade_engine #(.CH(CH), .DW(DW), .PRESC(PRESC)) u_dut (
        .clk12       (clk12),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_rdy      (rx_rdy),
        .frame_abort (frame_abort),
        .pwm_out     (pwm_out),
        .busy        (busy),
        .frame_err   (frame_err)
    );

    always #5 clk12 = ~clk12;

    typedef struct {
        string    name;
        int       h0, h1, h2, h3;
        bit [3:0] mask;
        bit       busy;
    } win_t;

    win_t  win_q [$];
    string err_q [$];
    int    tests = 0;
    int    fails = 0;
    int    win_cnt [CH];

    function automatic int exp_hi(input win_t w, input int k);
        case (k)
            0:       return w.h0;
            1:       return w.h1;
            2:       return w.h2;
            default: return w.h3;
        endcase
    endfunction

    // Window monitor: measures one full PWM period per queued expectation.
    initial begin : mon_win
        win_t w;
        forever begin
            @(negedge clk12);
            if (win_q.size() > 0) begin
                for (int k = 0; k < CH; k++) win_cnt[k] = 0;
                for (int c = 0; c < W; c++) begin
                    for (int k = 0; k < CH; k++) begin
                        if (pwm_out[k] === 1'b1) win_cnt[k]++;
                    end
                    if (c != W - 1) @(negedge clk12);
                end
                w = win_q.pop_front();
                $display("[TB] window %s: hi=%0d/%0d/%0d/%0d busy=%b", w.name,
                         win_cnt[0], win_cnt[1], win_cnt[2], win_cnt[3], busy);
                for (int k = 0; k < CH; k++) begin
                    if (w.mask[k]) begin
                        tests++;
                        if (win_cnt[k] != exp_hi(w, k)) begin
                            fails++;
                            $display("FAIL %s ch%0d high count: got %0d want %0d",
                                     w.name, k, win_cnt[k], exp_hi(w, k));
                        end
                    end
                end
                tests++;
                if (busy !== w.busy) begin
                    fails++;
                    $display("FAIL %s busy: got %b want %b", w.name, busy, w.busy);
                end
            end
        end
    end

    // Pulse monitor: every frame_err must be expected and last one cycle.
    initial begin : mon_err
        string s;
        forever begin
            @(negedge clk12);
            if (frame_err === 1'b1) begin
                tests++;
                if (err_q.size() == 0) begin
                    fails++;
                    $display("FAIL frame_err unexpected: got 1 want 0");
                end else begin
                    s = err_q.pop_front();
                    $display("[TB] frame_err pulse %s", s);
                end
                @(negedge clk12);
                tests++;
                if (frame_err !== 1'b0) begin
                    fails++;
                    $display("FAIL frame_err width: got %b want 0 on second cycle", frame_err);
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk12);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk12);
        rx_data = b;
        rx_rdy  = 1'b1;
        @(negedge clk12);
        rx_rdy  = 1'b0;
        repeat (2) @(negedge clk12);
    endtask

    task automatic send_tgt(input logic [7:0] t0, t1, t2, t3, r);
        send_byte(8'hA5);
        send_byte(t0);
        send_byte(t1);
        send_byte(t2);
        send_byte(t3);
        send_byte(r);
    endtask

    task automatic expect_win(input string nm, input int h0, h1, h2, h3,
                              input bit [3:0] m, input bit b);
        win_t w;
        w.name = nm;
        w.h0 = h0; w.h1 = h1; w.h2 = h2; w.h3 = h3;
        w.mask = m;
        w.busy = b;
        win_q.push_back(w);
        for (int i = 0; i < 3 * W; i++) begin
            if (win_q.size() == 0) break;
            @(negedge clk12);
        end
        if (win_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s window: got no measurement want one within %0d cycles", nm, 3 * W);
            win_q.delete();
        end
    endtask

    initial begin : stim
        int n;
        // Reset held for 3 cycles.
        reset = 1'b0;
        wait_cycles(3);
        reset = 1'b1;
        expect_win("reset", 0, 0, 0, 0, 4'hF, 1'b0);

        // Targets 20/10/08/FF at rate 0, default intensity 0xFF.
        send_tgt(8'h20, 8'h10, 8'h08, 8'hFF, 8'h00);
        wait_cycles(3 * W);
        expect_win("fading", 0, 0, 0, 0, 4'h0, 1'b1);
        wait_cycles(40 * W);
        // 0x20*0xFF=0x1FE0, 0x10*0xFF=0x0FF0, 0x08*0xFF=0x07F8
        expect_win("settled_int_ff", 31, 15, 7, 0, 4'h7, 1'b1);

        // Intensity 0x80: 0x1000, 0x0800, 0x0400.
        send_byte(8'h5A);
        send_byte(8'h80);
        wait_cycles(3 * W);
        expect_win("int_80", 16, 8, 4, 0, 4'h7, 1'b1);

        // Unknown command in IDLE.
        err_q.push_back("bad_cmd_33");
        send_byte(8'h33);
        wait_cycles(3);
        tests++;
        if (err_q.size() != 0) begin
            fails++;
            $display("FAIL frame_err seen: got %0d pending want 0", err_q.size());
        end
        wait_cycles(W);
        expect_win("after_err", 16, 8, 4, 0, 4'h7, 1'b1);

        // Partial frame, abort arriving together with a byte, then a full frame.
        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'h10);
        @(negedge clk12);
        frame_abort = 1'b1;
        rx_data     = 8'h10;
        rx_rdy      = 1'b1;
        @(negedge clk12);
        frame_abort = 1'b0;
        rx_rdy      = 1'b0;
        send_tgt(8'h01, 8'h02, 8'h03, 8'hFF, 8'h00);
        wait_cycles(35 * W);
        // 0x01*0x80=0x0080, 0x02*0x80=0x0100, 0x03*0x80=0x0180
        expect_win("abort", 0, 1, 1, 0, 4'h7, 1'b1);

        // Intensity back to 0xFF: 0x00FF, 0x01FE, 0x02FD.
        send_byte(8'h5A);
        send_byte(8'hFF);
        wait_cycles(2 * W);
        expect_win("int_ff", 0, 1, 2, 0, 4'h7, 1'b1);

        // Rate 3: ch0 01->05, one step per 4 periods; level 03 during periods 10..11.
        send_tgt(8'h05, 8'h02, 8'h03, 8'hFF, 8'h03);
        wait_cycles(10 * W - 3);
        expect_win("rate_mid", 2, 1, 2, 0, 4'h7, 1'b1);
        wait_cycles(12 * W);
        expect_win("rate_done", 4, 1, 2, 0, 4'h7, 1'b1);

        // Rate 0 again; wait for ch3 to reach 0xFF (full-scale duty).
        send_tgt(8'h05, 8'h02, 8'h03, 8'hFF, 8'h00);
        n = 0;
        while (busy !== 1'b0 && n < 200 * W) begin
            @(negedge clk12);
            n++;
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL busy_clear: got %b want 0 within %0d cycles", busy, 200 * W);
        end
        wait_cycles(2 * W);
        expect_win("full_scale", 4, 1, 2, 255, 4'hF, 1'b0);

        // Reset in the middle of a frame.
        send_byte(8'hA5);
        send_byte(8'h33);
        reset = 1'b0;
        wait_cycles(3);
        reset = 1'b1;
        expect_win("reset_midframe", 0, 0, 0, 0, 4'hF, 1'b0);
        // Parser must be back in IDLE: 0x33 is an unknown command again.
        err_q.push_back("bad_cmd_after_reset");
        send_byte(8'h33);
        wait_cycles(3);
        tests++;
        if (err_q.size() != 0) begin
            fails++;
            $display("FAIL err_after_reset: got %0d pending want 0", err_q.size());
        end

        wait_cycles(4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
